// File: rtl/ysyx_23060208_dsram.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_dsram
// Data-SRAM responder for the EXU load/store channels (AXI4-Lite style).
// Serves one read (AR->R) or one write (AW->W->B) at a time, with a
// configurable access latency between request acceptance and response.
// Read data is right-aligned (word >> 8*addr[1:0]); the EXU extends it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   dsram_aw{addr,valid,ready}    write address channel
//   dsram_w{data,strb,valid,ready} write data; wstrb is a one-hot size code
//                                 (3'b100 word, 3'b010 half, 3'b001 byte)
//   dsram_b{resp,valid,ready}     write response (OKAY / SLVERR)
//   dsram_ar{addr,valid,ready}    read address channel
//   dsram_r{data,resp,valid,ready} read response (OKAY / SLVERR)
// ---------------------------------------------------------------------------
module ysyx_23060208_dsram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dsram_awaddr,
    input  logic                  dsram_awvalid,
    output logic                  dsram_awready,
    input  logic [DATA_WIDTH-1:0] dsram_wdata,
    input  logic [2:0]            dsram_wstrb,
    input  logic                  dsram_wvalid,
    output logic                  dsram_wready,
    output logic [1:0]            dsram_bresp,
    output logic                  dsram_bvalid,
    input  logic                  dsram_bready,
    input  logic [DATA_WIDTH-1:0] dsram_araddr,
    input  logic                  dsram_arvalid,
    output logic                  dsram_arready,
    output logic [DATA_WIDTH-1:0] dsram_rdata,
    output logic [1:0]            dsram_rresp,
    output logic                  dsram_rvalid,
    input  logic                  dsram_rready
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, R_LAT, R_RESP, W_DATA, W_LAT, W_RESP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    werr_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic [DATA_WIDTH-1:0]   offs;
    logic [IDX_W-1:0]        idx;
    logic                    range_err;
    logic                    werr;
    logic [3:0]              wr_mask;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic                    cnt_zero;

    // Legal size codes and their alignment rules; anything else is an error.
    function automatic logic size_err(input logic [2:0] strb, input logic [1:0] lo);
        logic err;
        case (strb)
            3'b100:  err = (lo != 2'b00);
            3'b010:  err = lo[0];
            3'b001:  err = 1'b0;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // The latched address serves both directions, so one decode is shared.
    always_comb begin
        offs      = addr_q - BASE_ADDR;
        idx       = offs[IDX_W+1:2];
        range_err = (addr_q < BASE_ADDR) || ((offs >> 2) >= DATA_WIDTH'(MEM_WORDS));
        werr      = range_err || size_err(dsram_wstrb, addr_q[1:0]);
        rd_shift  = mem[idx] >> {addr_q[1:0], 3'b000};
        cnt_zero  = (cnt_q == '0);
    end

    // Replicate sub-word store data across the word so the byte mask alone
    // selects which lanes land in the array.
    always_comb begin
        wr_mask = 4'b0000;
        wr_word = dsram_wdata;
        case (dsram_wstrb)
            3'b100: wr_mask = 4'b1111;
            3'b010: begin
                wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{dsram_wdata[15:0]}};
            end
            3'b001: begin
                wr_mask = 4'b0001 << addr_q[1:0];
                wr_word = {4{dsram_wdata[7:0]}};
            end
            default: wr_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Readies depend only on state (and reset), never on the valids.
    always_comb begin
        state_d       = state_q;
        dsram_arready = 1'b0;
        dsram_awready = 1'b0;
        dsram_wready  = 1'b0;
        case (state_q)
            IDLE: begin
                dsram_arready = !rst;
                dsram_awready = !rst;
                if (dsram_arvalid)      state_d = R_LAT;
                else if (dsram_awvalid) state_d = W_DATA;
            end
            R_LAT:  if (cnt_zero) state_d = R_RESP;
            R_RESP: if (dsram_rready) state_d = IDLE;
            W_DATA: begin
                dsram_wready = !rst;
                if (dsram_wvalid) state_d = W_LAT;
            end
            W_LAT:  if (cnt_zero) state_d = W_RESP;
            W_RESP: if (dsram_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            werr_q       <= 1'b0;
            dsram_rdata  <= '0;
            dsram_rresp  <= RESP_OKAY;
            dsram_rvalid <= 1'b0;
            dsram_bresp  <= RESP_OKAY;
            dsram_bvalid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dsram_arvalid) begin
                        addr_q <= dsram_araddr;
                        cnt_q  <= CNT_LOAD;
                    end else if (dsram_awvalid) begin
                        addr_q <= dsram_awaddr;
                    end
                end
                R_LAT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        dsram_rvalid <= 1'b1;
                        dsram_rdata  <= range_err ? '0 : rd_shift;
                        dsram_rresp  <= range_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_RESP: if (dsram_rready) dsram_rvalid <= 1'b0;
                W_DATA: begin
                    if (dsram_wvalid) begin
                        cnt_q  <= CNT_LOAD;
                        werr_q <= werr;
                    end
                end
                W_LAT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        dsram_bvalid <= 1'b1;
                        dsram_bresp  <= werr_q ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: if (dsram_bready) dsram_bvalid <= 1'b0;
                default: ;
            endcase
        end
    end

    // The array commits on the W handshake, so a later reset cannot undo it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == W_DATA && dsram_wvalid && !werr) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

endmodule
